azadi_spi_loader: RTL and testbench

- Parametrised SPI-slave boot loader that receives a program image over SPI and writes it word-by-word into instruction memory (ICCM).
- Single clock domain: SCK, CSB and SDI are oversampled and synchronised into clk_i, so there is no SCK-clocked logic.
- Adds over the previous loader:
  - configurable word width, byte order, base address and end marker;
  - a buffering FIFO with a ready/valid write port;
  - sticky status flags for done, overflow and framing error.

---
 rtl/azadi_spi_loader.sv | 123 ++++++++++++
 tb/tb_azadi_spi_loader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/azadi_spi_loader.sv
// azadi_spi_loader: oversampled SPI-slave boot loader writing words into ICCM through a FIFO
module azadi_spi_loader #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter bit BYTE_SWAP = 1'b1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter logic [DATA_WIDTH-1:0] END_WORD = DATA_WIDTH'(32'h00FF_FF00)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sck_i,
  input  logic                  sdi_i,
  input  logic                  csb_i,
  output logic                  sdo_o,
  input  logic                  clr_i,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  output logic                  done_o,
  output logic                  ovf_o,
  output logic                  frame_err_o,
  output logic [ADDR_WIDTH-1:0] word_cnt_o
);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, CHECK = 2'd2, DONE = 2'd3;
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [2:0] sck_s;
  logic [1:0] csb_s, sdi_s;
  logic [1:0] state;
  logic [CW-1:0] bit_cnt;
  logic [DATA_WIDTH-1:0] shreg, word;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  logic sck_rise, csb, full, push, pop, is_end;
  for (genvar i = 0; i < DATA_WIDTH / 8; i++) begin : g_swap
    assign word[8*i +: 8] = BYTE_SWAP ? shreg[DATA_WIDTH-8-8*i +: 8] : shreg[8*i +: 8];
  end
  assign sck_rise = sck_s[1] & ~sck_s[2];
  assign csb = csb_s[1];
  assign is_end = word == END_WORD;
  assign full = cnt == (PW + 1)'(FIFO_DEPTH);
  assign wvalid_o = cnt != '0;
  assign pop = wvalid_o & wready_i;
  assign push = state == CHECK & ~is_end & (~full | pop);
  assign wdata_o = wvalid_o ? mem[rp] : '0;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_s <= '0;
      csb_s <= '1;
      sdi_s <= '0;
    end else begin
      sck_s <= {sck_s[1:0], sck_i};
      csb_s <= {csb_s[0], csb_i};
      sdi_s <= {sdi_s[0], sdi_i};
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      bit_cnt <= '0;
      shreg <= '0;
      done_o <= 1'b0;
      ovf_o <= 1'b0;
      frame_err_o <= 1'b0;
      sdo_o <= 1'b0;
    end else begin
      sdo_o <= done_o;
      if (clr_i) begin
        done_o <= 1'b0;
        ovf_o <= 1'b0;
        frame_err_o <= 1'b0;
      end
      if (state == IDLE) begin
        bit_cnt <= '0;
        if (!csb) state <= SHIFT;
      end else if (state == SHIFT) begin
        if (bit_cnt == CW'(DATA_WIDTH)) begin
          bit_cnt <= '0;
          state <= CHECK;
        end else if (csb) begin
          bit_cnt <= '0;
          state <= IDLE;
          if (bit_cnt != '0) frame_err_o <= 1'b1;
        end else if (sck_rise) begin
          shreg <= {shreg[DATA_WIDTH-2:0], sdi_s[1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (state == CHECK) begin
        state <= is_end ? DONE : SHIFT;
        if (is_end) done_o <= 1'b1;
        else if (!push) ovf_o <= 1'b1;
      end else if (clr_i) begin
        state <= IDLE;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem[wp] <= word;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      waddr_o <= BASE_ADDR;
      word_cnt_o <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      if (clr_i) begin
        waddr_o <= BASE_ADDR;
        word_cnt_o <= '0;
      end else if (pop) begin
        waddr_o <= waddr_o + 1'b1;
        word_cnt_o <= word_cnt_o + {{(ADDR_WIDTH-1){1'b0}}, ~&word_cnt_o};
      end
    end
  end
endmodule

// File: tb/tb_azadi_spi_loader.sv
// tb_azadi_spi_loader: scoreboard bench for two loader configurations sharing one SPI bus
module tb_azadi_spi_loader;
  logic clk = 1'b0;
  logic rst1 = 1'b1, rst2 = 1'b1;
  logic sck = 1'b0, sdi = 1'b0, csb = 1'b1;
  logic clr1 = 1'b0, clr2 = 1'b0, wready1 = 1'b1, wready2 = 1'b0;
  logic sdo1, wvalid1, done1, ovf1, ferr1;
  logic sdo2, wvalid2, done2, ovf2, ferr2;
  logic [12:0] waddr1, wcnt1, waddr2, wcnt2;
  logic [31:0] wdata1, wdata2;
  logic [44:0] q1[$], q2[$];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  azadi_spi_loader dut1 (
    .clk_i(clk), .rst_i(rst1), .sck_i(sck), .sdi_i(sdi), .csb_i(csb), .sdo_o(sdo1),
    .clr_i(clr1), .waddr_o(waddr1), .wdata_o(wdata1), .wvalid_o(wvalid1), .wready_i(wready1),
    .done_o(done1), .ovf_o(ovf1), .frame_err_o(ferr1), .word_cnt_o(wcnt1)
  );
  azadi_spi_loader #(.BYTE_SWAP(1'b0), .BASE_ADDR(13'd8190)) dut2 (
    .clk_i(clk), .rst_i(rst2), .sck_i(sck), .sdi_i(sdi), .csb_i(csb), .sdo_o(sdo2),
    .clr_i(clr2), .waddr_o(waddr2), .wdata_o(wdata2), .wvalid_o(wvalid2), .wready_i(wready2),
    .done_o(done2), .ovf_o(ovf2), .frame_err_o(ferr2), .word_cnt_o(wcnt2)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    #2;
    if (wvalid1 && wready1) begin
      if (q1.size() == 0) chk("wr1_unexpected", {waddr1, wdata1}, 45'h0);
      else chk("wr1", {waddr1, wdata1}, q1.pop_front());
    end
    if (wvalid2 && wready2) begin
      if (q2.size() == 0) chk("wr2_unexpected", {waddr2, wdata2}, 45'h0);
      else chk("wr2", {waddr2, wdata2}, q2.pop_front());
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic spi_bit(input logic b);
    sdi = b;
    cyc(4);
    sck = 1'b1;
    cyc(4);
    sck = 1'b0;
  endtask
  task automatic spi_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) spi_bit(w[i]);
  endtask
  task automatic frame_on();
    csb = 1'b0;
    cyc(4);
  endtask
  task automatic frame_off();
    cyc(4);
    csb = 1'b1;
    cyc(10);
  endtask
  task automatic pulse_clr1();
    clr1 = 1'b1;
    cyc(1);
    clr1 = 1'b0;
    cyc(2);
  endtask
  task automatic chk_reset1(input string tag);
    chk({tag, "_wvalid"}, wvalid1, 0);
    chk({tag, "_done"}, done1, 0);
    chk({tag, "_sdo"}, sdo1, 0);
    chk({tag, "_ovf"}, ovf1, 0);
    chk({tag, "_ferr"}, ferr1, 0);
    chk({tag, "_waddr"}, waddr1, 0);
    chk({tag, "_wdata"}, wdata1, 0);
    chk({tag, "_wcnt"}, wcnt1, 0);
  endtask
  initial begin
    cyc(3);
    rst1 = 1'b0;
    cyc(1);
    chk_reset1("rst");
    q1.push_back({13'd0, 32'h01020304});
    q1.push_back({13'd1, 32'h05060708});
    q1.push_back({13'd2, 32'h090A0B0C});
    frame_on();
    spi_word(32'h04030201);
    spi_word(32'h08070605);
    spi_word(32'h0C0B0A09);
    spi_word(32'h00FFFF00);
    spi_word(32'h12345678);
    frame_off();
    cyc(20);
    chk("img_done", done1, 1);
    chk("img_sdo", sdo1, 1);
    chk("img_wcnt", wcnt1, 3);
    chk("img_q", q1.size(), 0);
    pulse_clr1();
    chk("clr_done", done1, 0);
    chk("clr_sdo", sdo1, 0);
    chk("clr_wcnt", wcnt1, 0);
    chk("clr_waddr", waddr1, 0);
    wready1 = 1'b0;
    q1.push_back({13'd0, 32'h14131211});
    q1.push_back({13'd1, 32'h24232221});
    q1.push_back({13'd2, 32'h34333231});
    q1.push_back({13'd3, 32'h44434241});
    frame_on();
    spi_word(32'h11121314);
    spi_word(32'h21222324);
    spi_word(32'h31323334);
    spi_word(32'h41424344);
    spi_word(32'h51525354);
    spi_word(32'h61626364);
    frame_off();
    chk("ovf_flag", ovf1, 1);
    chk("ovf_wvalid", wvalid1, 1);
    chk("ovf_wcnt0", wcnt1, 0);
    wready1 = 1'b1;
    cyc(10);
    chk("ovf_wcnt", wcnt1, 4);
    chk("ovf_q", q1.size(), 0);
    frame_on();
    for (int i = 0; i < 17; i++) spi_bit(i[0]);
    frame_off();
    chk("ferr_flag", ferr1, 1);
    chk("ferr_wcnt", wcnt1, 4);
    chk("ferr_wvalid", wvalid1, 0);
    q1.push_back({13'd4, 32'h0D0C0B0A});
    frame_on();
    spi_word(32'h0A0B0C0D);
    frame_off();
    chk("ferr_next_wcnt", wcnt1, 5);
    chk("ferr_sticky", ferr1, 1);
    chk("ferr_q", q1.size(), 0);
    wready1 = 1'b0;
    frame_on();
    spi_word(32'h55667788);
    for (int i = 0; i < 10; i++) spi_bit(1'b1);
    chk("mid_wvalid", wvalid1, 1);
    rst1 = 1'b1;
    cyc(2);
    rst1 = 1'b0;
    cyc(1);
    chk_reset1("midrst");
    csb = 1'b1;
    cyc(10);
    wready1 = 1'b1;
    q1.push_back({13'd0, 32'h44332211});
    frame_on();
    spi_word(32'h11223344);
    spi_word(32'h00FFFF00);
    frame_off();
    chk("reimg_done", done1, 1);
    pulse_clr1();
    chk_reset1("clrdone");
    q1.push_back({13'd0, 32'hCCBBAA99});
    frame_on();
    spi_word(32'h99AABBCC);
    frame_off();
    chk("post_wcnt", wcnt1, 1);
    chk("post_waddr", waddr1, 1);
    chk("post_q", q1.size(), 0);
    rst1 = 1'b1;
    rst2 = 1'b0;
    cyc(3);
    chk("d2_rst_waddr", waddr2, 8190);
    q2.push_back({13'd8190, 32'hDEADBEEF});
    q2.push_back({13'd8191, 32'h12345678});
    q2.push_back({13'd0, 32'hCAFEF00D});
    frame_on();
    spi_word(32'hDEADBEEF);
    spi_word(32'h12345678);
    spi_word(32'hCAFEF00D);
    spi_word(32'h00FFFF00);
    frame_off();
    chk("d2_wvalid", wvalid2, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("stall_waddr", waddr2, 8190);
      chk("stall_wdata", wdata2, 32'hDEADBEEF);
    end
    wready2 = 1'b1;
    cyc(10);
    chk("d2_wcnt", wcnt2, 3);
    chk("d2_waddr_wrap", waddr2, 1);
    chk("d2_done", done2, 1);
    chk("d2_sdo", sdo2, 1);
    chk("d2_q", q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
